// File: rtl/alu_share_pkg.sv
// Shared types, default widths and ALU opcode encodings for the ALU-sharing controller.
package alu_share_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_SEL_WIDTH  = 3;
  localparam int unsigned DEF_NUM_REQ    = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} ctrl_state_t;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] NOT = 3'b101;
  localparam logic [2:0] SHL = 3'b110;
  localparam logic [2:0] SHR = 3'b111;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester request/response channels plus the port to the shared external ALU.
interface alu_share_ctrl_if #(
  parameter int unsigned DATA_WIDTH = alu_share_pkg::DEF_DATA_WIDTH,
  parameter int unsigned SEL_WIDTH  = alu_share_pkg::DEF_SEL_WIDTH,
  parameter int unsigned NUM_REQ    = alu_share_pkg::DEF_NUM_REQ
) ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sel;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [DATA_WIDTH-1:0]         alu_a;
  logic [DATA_WIDTH-1:0]         alu_b;
  logic [SEL_WIDTH-1:0]          alu_sel;
  logic [DATA_WIDTH-1:0]         alu_out;

  // Requesters and the ALU together form the master side.
  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_sel
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_sel
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU among NUM_REQ requesters: accept, issue, respond.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned SEL_WIDTH  = DEF_SEL_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
  input  logic             clk,
  input  logic             reset,
  alu_share_ctrl_if.slave  bus,
  output logic             busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  ctrl_state_t           state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_found;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      res_q       <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      res_q       <= res_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Operands stay latched after ISSUE so the ALU inputs never change until the next accept.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    res_d       = res_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          a_d     = bus.req_a[32'(arb_idx) * DATA_WIDTH +: DATA_WIDTH];
          b_d     = bus.req_b[32'(arb_idx) * DATA_WIDTH +: DATA_WIDTH];
          sel_d   = bus.req_sel[32'(arb_idx) * SEL_WIDTH +: SEL_WIDTH];
          grant_d = arb_idx;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        res_d       = bus.alu_out;
        rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          busy_d      = 1'b0;
          ptr_d       = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && !reset) bus.req_ready = arb_grant;
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = res_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = sel_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU on the shared port.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  logic clk;
  logic reset;
  logic busy;
  int   n_cmp;
  int   n_err;

  alu_share_ctrl_if #(.DATA_WIDTH(16), .SEL_WIDTH(3), .NUM_REQ(4)) bus ();

  alu_share_ctrl #(.DATA_WIDTH(16), .SEL_WIDTH(3), .NUM_REQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  function automatic logic [15:0] alu_f(input logic [2:0] s, input logic [15:0] a,
                                        input logic [15:0] b);
    case (s)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      NOT:     return ~a;
      SHL:     return a << b[3:0];
      default: return a >> b[3:0];
    endcase
  endfunction

  assign bus.alu_out = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] s);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
    bus.req_sel[i*3 +: 3] = s;
  endtask

  logic [15:0] exp_rr [4];
  logic [3:0]  oh;

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = '0;
    exp_rr[0] = 16'h1234;
    exp_rr[1] = 16'h4FFF;
    exp_rr[2] = 16'h0FF0;
    exp_rr[3] = 16'h0030;

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'h0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // Single request from requester 0
    set_req(0, 16'h0123, 16'h0456, ADD);
    bus.rsp_ready = 4'hF;
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    chk("single_idle_busy", 32'(busy), 32'h0);
    tick();
    bus.req_valid = '0;
    #1;
    chk("single_issue_a", 32'(bus.alu_a), 32'h0123);
    chk("single_issue_b", 32'(bus.alu_b), 32'h0456);
    chk("single_issue_sel", 32'(bus.alu_sel), 32'h0);
    chk("single_issue_ready", 32'(bus.req_ready), 32'h0);
    chk("single_issue_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("single_issue_busy", 32'(busy), 32'h1);
    tick();
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("single_rsp_data", 32'(bus.rsp_data), 32'h0579);
    chk("single_rsp_busy", 32'(busy), 32'h1);
    tick();
    chk("single_done_busy", 32'(busy), 32'h0);
    chk("single_done_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("single_hold_a", 32'(bus.alu_a), 32'h0123);

    // Round robin from pointer 0, all requesters valid
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 16'h1000, 16'h0234, ADD);
    set_req(1, 16'h5000, 16'h0001, SUB);
    set_req(2, 16'h00FF, 16'h0F0F, XOR);
    set_req(3, 16'h0003, 16'h0004, SHL);
    bus.req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      chk("rr_grant", 32'(bus.req_ready), 32'(oh));
      tick();
      chk("rr_issue_block", 32'(bus.req_ready), 32'h0);
      tick();
      chk("rr_resp_block", 32'(bus.req_ready), 32'h0);
      chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
      chk("rr_rsp_data", 32'(bus.rsp_data), 32'(exp_rr[k % 4]));
      tick();
    end

    // Backpressure on requester 2 while requester 1 is ready
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 4'b0010;
    #1;
    chk("bp_grant", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b1011;
    #1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h4);
      chk("bp_rsp_data", 32'(bus.rsp_data), 32'h0FF0);
      chk("bp_no_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.req_valid = 4'b1001;
    bus.rsp_ready = 4'b0110;
    #1;
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'h4);
    tick();
    chk("bp_done_busy", 32'(busy), 32'h0);
    chk("bp_done_rsp", 32'(bus.rsp_valid), 32'h0);

    // Pointer at 3 with only requesters 0 and 3 valid
    bus.rsp_ready = 4'hF;
    chk("wrap_first", 32'(bus.req_ready), 32'h8);
    tick();
    tick();
    chk("wrap_first_rsp", 32'(bus.rsp_valid), 32'h8);
    chk("wrap_first_data", 32'(bus.rsp_data), 32'h0030);
    tick();
    chk("wrap_second", 32'(bus.req_ready), 32'h1);
    tick();
    tick();
    chk("wrap_second_rsp", 32'(bus.rsp_valid), 32'h1);
    chk("wrap_second_data", 32'(bus.rsp_data), 32'h1234);

    // Reset during RESP aborts the transaction
    reset = 1'b1;
    #1;
    chk("midrst_ready_low", 32'(bus.req_ready), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_alu_a", 32'(bus.alu_a), 32'h0);
    chk("midrst_alu_b", 32'(bus.alu_b), 32'h0);
    chk("midrst_alu_sel", 32'(bus.alu_sel), 32'h0);
    chk("midrst_ptr", 32'(bus.req_ready), 32'h1);

    // Requester 1 after reset, ADD wrapping to zero
    set_req(1, 16'hFFFF, 16'h0001, ADD);
    bus.req_valid = 4'b0010;
    #1;
    chk("post_rst_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    #1;
    chk("pass_sel", 32'(bus.alu_sel), 32'h0);
    chk("pass_a", 32'(bus.alu_a), 32'hFFFF);
    tick();
    chk("pass_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    chk("pass_rsp_data", 32'(bus.rsp_data), 32'h0000);
    tick();
    chk("pass_done_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
